// File: rtl/alu_cmd_issue_if.sv
// alu_cmd_issue_if: command and response channels of the ALU issue stage
//   cmd: cmd_valid/cmd_ready handshake carrying operands cmd_a, cmd_b and opcode cmd_op
//   rsp: rsp_valid/rsp_ready handshake carrying rsp_res, rsp_carry and originating rsp_op
//   master = sequencer side, slave = issue stage
interface alu_cmd_issue_if #(parameter int DW = 8);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [2:0]    cmd_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_res;
  logic          rsp_carry;
  logic [2:0]    rsp_op;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_res, rsp_carry, rsp_op
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_res, rsp_carry, rsp_op
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: buffers ALU commands in a FIFO, drives the ALU from the head, returns registered results
//   clk, rstn       clock, asynchronous active-low reset
//   bus             command/response channels (slave side)
//   alu_a/b/op      FIFO head to the combinational ALU, zero when empty
//   alu_res/carry   ALU outputs, captured into the response slot
//   fifo_cnt        FIFO occupancy
//   done_cnt        consumed responses, wraps modulo 2^CW
module alu_cmd_issue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  alu_cmd_issue_if.slave           bus,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [2:0]               alu_op,
  input  logic [DW-1:0]            alu_res,
  input  logic                     alu_carry,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [CW-1:0]            done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  typedef enum logic {EMPTY, FULL} slot_t;
  slot_t         slot;
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [2:0]    mem_op [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, nonempty;
  assign nonempty = fifo_cnt != '0;
  // ready depends only on occupancy, so it never follows rsp_ready combinationally
  assign bus.cmd_ready = fifo_cnt != CAP;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = nonempty && (slot == EMPTY || bus.rsp_ready);
  assign alu_a = nonempty ? mem_a[rd_ptr] : '0;
  assign alu_b = nonempty ? mem_b[rd_ptr] : '0;
  assign alu_op = nonempty ? mem_op[rd_ptr] : '0;
  assign bus.rsp_valid = slot == FULL;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.cmd_a;
      mem_b[wr_ptr] <= bus.cmd_b;
      mem_op[wr_ptr] <= bus.cmd_op;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // response slot: refilled straight from the ALU whenever it is free or being drained
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot <= EMPTY;
      bus.rsp_res <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_op <= '0;
    end else if (pop) begin
      slot <= FULL;
      bus.rsp_res <= alu_res;
      bus.rsp_carry <= alu_carry;
      bus.rsp_op <= alu_op;
    end else if (slot == FULL && bus.rsp_ready) begin
      slot <= EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) done_cnt <= '0;
    else if (bus.rsp_valid && bus.rsp_ready) done_cnt <= done_cnt + 1'b1;
  end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: randomized and directed checks of alu_cmd_issue against a queue-based reference model
module tb_alu_cmd_issue;
  localparam int CW = 4;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [8:0] alu_o;
  logic [2:0] fifo_cnt;
  logic [CW-1:0] done_cnt;
  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q [$];
  logic [CW-1:0] exp_done;
  logic last_push;
  logic [CW-1:0] d0;
  logic [7:0] ta [7] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
  logic [7:0] tb_ [7] = '{8'h01, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h02, 8'h02};
  logic [2:0] top [7] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] tr [7] = '{8'h10, 8'h00, 8'hFF, 8'hFF, 8'hF0, 8'h03, 8'h3C};
  alu_cmd_issue_if #(.DW(8)) bus ();
  alu_cmd_issue #(.DW(8), .DEPTH(4), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_o[7:0]), .alu_carry(alu_o[8]),
    .fifo_cnt(fifo_cnt), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, a >> b[2:0]};
      default: return {1'b0, a << b[2:0]};
    endcase
  endfunction
  assign alu_o = alu(alu_a, alu_b, alu_op);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_reset();
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_res", bus.rsp_res, 0);
    chk("rst_carry", bus.rsp_carry, 0);
    chk("rst_op", bus.rsp_op, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
  endtask
  // a command accepted at the last edge is still in the FIFO; anything older
  // and unconsumed means the oldest one is sitting in the response slot
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic rr);
    int outst, occ;
    logic ev;
    @(negedge clk);
    bus.cmd_valid = v;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.rsp_ready = rr;
    #1;
    outst = exp_q.size();
    ev = (outst - int'(last_push)) > 0;
    occ = outst - int'(ev);
    chk("rsp_valid", bus.rsp_valid, ev);
    chk("fifo_cnt", fifo_cnt, occ);
    chk("cmd_ready", bus.cmd_ready, occ != 4);
    chk("done_cnt", done_cnt, exp_done);
    if (ev) begin
      chk("rsp", {bus.rsp_op, bus.rsp_carry, bus.rsp_res}, exp_q[0]);
      if (rr) begin
        void'(exp_q.pop_front());
        exp_done = exp_done + 1'b1;
      end
    end
    last_push = v && occ != 4;
    if (last_push) exp_q.push_back({op, alu(a, b, op)});
  endtask
  task automatic idle(input logic rr);
    step(1'b0, 8'h00, 8'h00, 3'd0, rr);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    rstn = 1'b0;
    exp_done = '0;
    last_push = 1'b0;
    #3 chk_reset();
    #10 rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, ta[i], tb_[i], top[i], 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("tbl_res", bus.rsp_res, tr[i]);
      chk("tbl_op", bus.rsp_op, top[i]);
    end
    step(1'b1, 8'hFF, 8'h01, 3'd0, 1'b0);
    idle(1'b0);
    d0 = exp_done;
    for (int i = 0; i < 5; i++) idle(1'b0);
    chk("carry_res", bus.rsp_res, 8'h00);
    chk("carry_c", bus.rsp_carry, 1);
    chk("carry_hold_done", done_cnt, d0);
    idle(1'b1);
    idle(1'b1);
    chk("carry_done", done_cnt, 4'(d0 + 1));
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
    idle(1'b0);
    chk("bp_cnt", fifo_cnt, 4);
    chk("bp_ready", bus.cmd_ready, 0);
    d0 = exp_done;
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("bp_done", done_cnt, 4'(d0 + 5));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + i), 8'h01, 3'd0, 1'b1);
      chk("stream_cnt", fifo_cnt <= 3'd1, 1);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, 8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(2) != 0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
    idle(1'b0);
    chk("pre_rst_cnt", fifo_cnt, 3);
    #2 rstn = 1'b0;
    #1 chk_reset();
    exp_q.delete();
    exp_done = '0;
    last_push = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    step(1'b1, 8'h02, 8'h03, 3'd7, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_res", bus.rsp_res, 8'h10);
    chk("post_rst_op", bus.rsp_op, 7);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 8'h01, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("wrap_done", done_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
